// File: rtl/riscv_mon_pkg.sv
// Shared types for the RISC-V end-of-program run monitor.
package riscv_mon_pkg;

    localparam int unsigned MON_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHECK,
        DONE
    } mon_state_t;

    typedef enum logic {
        HALT_ADDR,
        HALT_LOOP
    } halt_mode_t;

    // The register number field is named regnum because "reg" is a keyword.
    typedef struct packed {
        logic                en;
        logic [4:0]          regnum;
        logic [MON_XLEN-1:0] data;
    } exp_entry_t;

endpackage

// File: rtl/riscv_mon_exp_table.sv
// Expected-register-value table: one write port, combinational read by index.
module riscv_mon_exp_table
    import riscv_mon_pkg::*;
#(
    parameter int unsigned NUM_CHECKS = 4,
    parameter int unsigned XLEN       = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [$clog2(NUM_CHECKS)-1:0] widx,
    input  logic                          wen,
    input  logic [4:0]                    wreg,
    input  logic [XLEN-1:0]               wdata,
    input  logic [$clog2(NUM_CHECKS)-1:0] ridx,
    output logic                          ren,
    output logic [4:0]                    rreg,
    output logic [XLEN-1:0]               rdata
);

    exp_entry_t tbl [NUM_CHECKS];
    exp_entry_t rd_entry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
                tbl[i] <= '0;
            end
        end else if (we) begin
            tbl[widx] <= '{en: wen, regnum: wreg, data: wdata};
        end
    end

    assign rd_entry = tbl[ridx];
    assign ren      = rd_entry.en;
    assign rreg     = rd_entry.regnum;
    assign rdata    = rd_entry.data;

endmodule

// File: rtl/riscv_run_monitor.sv
// End-of-program monitor: detects halt from retired PCs (or times out),
// then walks the expected-value table against a register-file read port.
module riscv_run_monitor
    import riscv_mon_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_CHECKS = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned STALL_REPS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          mode,
    input  logic [XLEN-1:0]               fin_addr,
    input  logic [CNT_W-1:0]              timeout_limit,
    input  logic                          retire,
    input  logic [XLEN-1:0]               pc,
    input  logic                          exp_we,
    input  logic [$clog2(NUM_CHECKS)-1:0] exp_idx,
    input  logic                          exp_en,
    input  logic [4:0]                    exp_reg,
    input  logic [XLEN-1:0]               exp_data,
    output logic [4:0]                    rf_raddr,
    input  logic [XLEN-1:0]               rf_rdata,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          fail,
    output logic                          timeout,
    output logic [$clog2(NUM_CHECKS)-1:0] fail_idx,
    output logic [XLEN-1:0]               fail_data,
    output logic [CNT_W-1:0]              cycle_count,
    output logic [CNT_W-1:0]              instret_count
);

    localparam int unsigned IW = $clog2(NUM_CHECKS);
    localparam int unsigned SW = $clog2(STALL_REPS + 1);

    mon_state_t       state, state_n;
    logic [IW-1:0]    chk_idx;
    logic [SW-1:0]    stall_cnt, stall_n;
    logic [XLEN-1:0]  prev_pc;
    logic             prev_vld;
    logic [CNT_W-1:0] cyc_n, ins_n;
    logic             idle_like, same_pc, halt, tmo_hit, chk_mis, chk_last;
    logic             ent_en;
    logic [4:0]       ent_reg;
    logic [XLEN-1:0]  ent_data;

    riscv_mon_exp_table #(
        .NUM_CHECKS (NUM_CHECKS),
        .XLEN       (XLEN)
    ) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (exp_we && idle_like),
        .widx  (exp_idx),
        .wen   (exp_en),
        .wreg  (exp_reg),
        .wdata (exp_data),
        .ridx  (chk_idx),
        .ren   (ent_en),
        .rreg  (ent_reg),
        .rdata (ent_data)
    );

    assign idle_like = (state == IDLE) || (state == DONE);
    assign busy      = (state == RUN) || (state == CHECK);
    assign rf_raddr  = (state == CHECK) ? ent_reg : '0;

    assign cyc_n = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
    assign ins_n = (retire && !(&instret_count)) ? instret_count + CNT_W'(1) : instret_count;

    // A repeat needs a previously retired PC in this run; the first retire never counts.
    assign same_pc = prev_vld && (pc == prev_pc);
    assign stall_n = (retire && same_pc) ? stall_cnt + SW'(1) : '0;
    assign halt    = (halt_mode_t'(mode) == HALT_LOOP)
                   ? (retire && same_pc && (stall_n == SW'(STALL_REPS - 1)))
                   : (retire && (pc == fin_addr));
    assign tmo_hit = (timeout_limit != '0) && (cyc_n == timeout_limit) && !halt;

    assign chk_mis  = ent_en && (rf_rdata != ent_data);
    assign chk_last = (chk_idx == IW'(NUM_CHECKS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE: if (start) state_n = RUN;
            RUN: begin
                if (halt)         state_n = CHECK;
                else if (tmo_hit) state_n = DONE;
            end
            CHECK: if (chk_mis || chk_last) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            timeout       <= 1'b0;
            fail_idx      <= '0;
            fail_data     <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
            stall_cnt     <= '0;
            prev_pc       <= '0;
            prev_vld      <= 1'b0;
            chk_idx       <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        fail          <= 1'b0;
                        timeout       <= 1'b0;
                        fail_idx      <= '0;
                        fail_data     <= '0;
                        cycle_count   <= '0;
                        instret_count <= '0;
                        stall_cnt     <= '0;
                        prev_pc       <= '0;
                        prev_vld      <= 1'b0;
                        chk_idx       <= '0;
                    end
                end
                RUN: begin
                    cycle_count   <= cyc_n;
                    instret_count <= ins_n;
                    if (retire) begin
                        prev_pc   <= pc;
                        prev_vld  <= 1'b1;
                        stall_cnt <= stall_n;
                    end
                    if (halt) begin
                        chk_idx <= '0;
                    end else if (tmo_hit) begin
                        done    <= 1'b1;
                        fail    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                CHECK: begin
                    if (chk_mis) begin
                        fail_idx  <= chk_idx;
                        fail_data <= rf_rdata;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                    end else if (chk_last) begin
                        done <= 1'b1;
                        pass <= 1'b1;
                    end else begin
                        chk_idx <= chk_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Directed bench for riscv_run_monitor: vector table of runs plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_riscv_run_monitor;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_CHECKS = 4;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned STALL_REPS = 4;

    logic             clk = 1'b0;
    logic             reset, start, mode, retire, exp_we, exp_en;
    logic [XLEN-1:0]  fin_addr, pc, exp_data, rf_rdata, fail_data;
    logic [CNT_W-1:0] timeout_limit, cycle_count, instret_count;
    logic [1:0]       exp_idx, fail_idx;
    logic [4:0]       exp_reg, rf_raddr;
    logic             busy, done, pass, fail, timeout;

    logic [XLEN-1:0]  rf [32];
    assign rf_rdata = rf[rf_raddr];

    int checks = 0;
    int errors = 0;

    riscv_run_monitor #(
        .XLEN       (XLEN),
        .NUM_CHECKS (NUM_CHECKS),
        .CNT_W      (CNT_W),
        .STALL_REPS (STALL_REPS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .mode          (mode),
        .fin_addr      (fin_addr),
        .timeout_limit (timeout_limit),
        .retire        (retire),
        .pc            (pc),
        .exp_we        (exp_we),
        .exp_idx       (exp_idx),
        .exp_en        (exp_en),
        .exp_reg       (exp_reg),
        .exp_data      (exp_data),
        .rf_raddr      (rf_raddr),
        .rf_rdata      (rf_rdata),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail          (fail),
        .timeout       (timeout),
        .fail_idx      (fail_idx),
        .fail_data     (fail_data),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fin;
        logic [31:0] limit;
        int          hit;     // RUN cycle on which pc == fin (0 = never)
        int          every;   // retire on cycles divisible by this
        logic        e_pass;
        logic        e_to;
        logic [31:0] e_cyc;
        logic [31:0] e_ins;
        int          e_k;     // cycle index at which done is first seen
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [1:0] idx, input logic en, input logic [4:0] r,
                               input logic [31:0] d);
        exp_we = 1'b1; exp_idx = idx; exp_en = en; exp_reg = r; exp_data = d;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_hit(input int n);
        for (int k = 1; k <= n; k++) begin
            retire = 1'b1;
            pc = (k == n) ? fin_addr : 32'(32'h1000 + k * 4);
            tick();
        end
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk("wait_done", {63'd0, done}, 64'd1);
    endtask

    initial begin
        int kd;
        int n;
        logic [31:0] loop_pcs [6];

        vecs[0] = '{32'hbc, 32'd50000, 40,  1, 1'b1, 1'b0, 32'd40,  32'd40,  44};
        vecs[1] = '{32'hbc, 32'd100,   0,   1, 1'b0, 1'b1, 32'd100, 32'd100, 100};
        vecs[2] = '{32'hbc, 32'd100,   100, 1, 1'b1, 1'b0, 32'd100, 32'd100, 104};
        vecs[3] = '{32'hbc, 32'd0,     60,  2, 1'b1, 1'b0, 32'd60,  32'd30,  64};
        vecs[4] = '{32'hbc, 32'd10,    11,  1, 1'b0, 1'b1, 32'd10,  32'd10,  10};
        vecs[5] = '{32'hbc, 32'd30,    30,  3, 1'b1, 1'b0, 32'd30,  32'd10,  34};

        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 32'h11);
        rf[10] = 32'h00fff05f;
        rf[2]  = 32'h00100000;

        reset = 1'b0; start = 1'b0; mode = 1'b0; retire = 1'b0; pc = '0;
        fin_addr = 32'hbc; timeout_limit = 32'd50000;
        exp_we = 1'b0; exp_idx = '0; exp_en = 1'b0; exp_reg = '0; exp_data = '0;

        #12;
        chk("rst_status", {59'd0, busy, done, pass, fail, timeout}, 64'd0);
        chk("rst_counts", {cycle_count, instret_count}, 64'd0);
        chk("rst_fail_raddr", {25'd0, fail_idx, fail_data, rf_raddr}, 64'd0);
        reset = 1'b1;
        tick();

        write_entry(2'd0, 1'b1, 5'd10, 32'h00fff05f);
        write_entry(2'd1, 1'b1, 5'd2,  32'h00100000);
        write_entry(2'd2, 1'b0, 5'd5,  32'hdeadbeef);
        write_entry(2'd3, 1'b0, 5'd7,  32'h12345678);

        // Vector runs: each starts from IDLE or DONE.
        for (int v = 0; v < 6; v++) begin
            mode = 1'b0;
            fin_addr = vecs[v].fin;
            timeout_limit = vecs[v].limit;
            begin_run();
            chk($sformatf("v%0d_restart", v),
                {busy, done, pass, fail, timeout, cycle_count, 27'd0}, {1'b1, 63'd0});
            kd = 0;
            for (int k = 1; k <= 3000; k++) begin
                retire = ((k % vecs[v].every) == 0);
                pc = (k == vecs[v].hit) ? vecs[v].fin : 32'(32'h1000 + k * 4);
                tick();
                if (done) begin
                    kd = k;
                    break;
                end
            end
            retire = 1'b0;
            chk($sformatf("v%0d_done_at", v), 64'(kd), 64'(vecs[v].e_k));
            chk($sformatf("v%0d_flags", v), {60'd0, busy, pass, fail, timeout},
                {60'd0, 1'b0, vecs[v].e_pass, !vecs[v].e_pass, vecs[v].e_to});
            chk($sformatf("v%0d_cycles", v), 64'(cycle_count), 64'(vecs[v].e_cyc));
            chk($sformatf("v%0d_instret", v), 64'(instret_count), 64'(vecs[v].e_ins));
        end

        // Mismatch at entry 1.
        rf[10] = 32'd2;
        write_entry(2'd0, 1'b1, 5'd2,  32'h00100000);
        write_entry(2'd1, 1'b1, 5'd10, 32'd3);
        mode = 1'b0; fin_addr = 32'hbc; timeout_limit = '0;
        begin_run();
        run_to_hit(5);
        chk("mis_raddr0", 64'(rf_raddr), 64'd2);
        tick();
        chk("mis_raddr1", {62'd0, done, busy}, 64'd1);
        chk("mis_raddr1_val", 64'(rf_raddr), 64'd10);
        tick();
        chk("mis_flags", {60'd0, done, pass, fail, timeout}, 64'b1010);
        chk("mis_idx_data", {30'd0, fail_idx, fail_data}, {30'd0, 2'd1, 32'h00000002});

        // Self-loop halt after four retires at one PC.
        write_entry(2'd1, 1'b1, 5'd10, 32'd2);
        loop_pcs = '{32'h40, 32'h44, 32'h48, 32'h48, 32'h48, 32'h48};
        mode = 1'b1;
        begin_run();
        for (int k = 0; k < 6; k++) begin
            retire = 1'b1;
            pc = loop_pcs[k];
            tick();
        end
        chk("loop_instret", {cycle_count, instret_count}, {32'd6, 32'd6});
        tick();
        chk("loop_frozen", {31'd0, busy, cycle_count}, {31'd0, 1'b1, 32'd6});
        wait_done(20, n);
        chk("loop_pass", {61'd0, pass, fail, timeout}, 64'b100);

        // Three repeats then a new PC must not halt; run ends by timeout.
        loop_pcs = '{32'h40, 32'h48, 32'h48, 32'h48, 32'h4c, 32'h50};
        timeout_limit = 32'd20;
        begin_run();
        for (int k = 1; k <= 40; k++) begin
            retire = 1'b1;
            pc = (k <= 6) ? loop_pcs[k-1] : 32'(32'h50 + (k - 6) * 4);
            tick();
            if (done) break;
        end
        chk("noloop_flags", {61'd0, pass, fail, timeout}, 64'b011);
        chk("noloop_cycles", 64'(cycle_count), 64'd20);

        // exp_we during RUN ignored; start during CHECK ignored.
        mode = 1'b0; fin_addr = 32'hbc; timeout_limit = '0;
        begin_run();
        for (int k = 1; k <= 10; k++) begin
            retire = 1'b1;
            pc = (k == 10) ? 32'hbc : 32'(32'h1000 + k * 4);
            exp_we = (k == 3); exp_idx = 2'd0; exp_en = 1'b1; exp_reg = 5'd10; exp_data = 32'hbad;
            tick();
        end
        exp_we = 1'b0; retire = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("chk_start_ign", {30'd0, busy, done, cycle_count}, {30'd0, 2'b10, 32'd10});
        wait_done(20, n);
        chk("chk_len_after_start", 64'(n), 64'd3);
        chk("we_run_ign", {62'd0, pass, fail}, 64'b10);

        // Asynchronous reset mid-CHECK clears outputs and the table.
        rf[10] = 32'hffffffff;
        rf[2]  = 32'h0;
        begin_run();
        run_to_hit(7);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_status", {59'd0, busy, done, pass, fail, timeout}, 64'd0);
        chk("arst_counts", {cycle_count, instret_count}, 64'd0);
        chk("arst_raddr", {25'd0, fail_idx, fail_data, rf_raddr}, 64'd0);
        #1 reset = 1'b1;
        tick();
        begin_run();
        run_to_hit(3);
        retire = 1'b0;
        wait_done(20, n);
        chk("empty_check_len", 64'(n), 64'd4);
        chk("empty_pass", {61'd0, pass, fail, timeout}, 64'b100);
        chk("empty_cycles", 64'(cycle_count), 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
